seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor and the sequential successor to our 32-bit gate-level ripple-carry adder. Operands of `WIDTH` bits are added `CHUNK` bits per clock through a single combinational ripple slice, with the carry held in a register between slices. A start/busy/done handshake frames each operation. It serves datapaths that trade latency for area, and it gives us width/slice sweeps of the ripple structure.

---
 rtl/chunk_adder_pkg.sv | 7 +
 rtl/chunk_adder.sv | 20 ++
 rtl/seq_chunk_adder.sv | 83 ++++++++
 tb/tb_seq_chunk_adder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_adder_pkg.sv
// chunk_adder_pkg: shared FSM state type and index-width helper for the sequential chunk adder
package chunk_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: W-bit ripple-carry adder built from full-adder gates
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout  = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract, CHUNK bits per clock through one ripple slice
module seq_chunk_adder
  import chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = idx_w(N);
  localparam int IW = idx_w(WIDTH);
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $fatal(1, "seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end
  state_t           state;
  logic [WIDTH-1:0] ra, rb;
  logic             carry;
  logic [KW-1:0]    k;
  logic [IW-1:0]    off;
  logic [CHUNK-1:0] sl_s;
  logic             sl_c, sl_m, last;
  assign off  = IW'(k * CHUNK);
  assign last = (k == KW'(N - 1));
  chunk_adder #(.W(CHUNK)) u_add (
    .a    (ra[off +: CHUNK]),
    .b    (rb[off +: CHUNK]),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_c),
    .c_msb(sl_m)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      carry <= 1'b0;
      k     <= '0;
      ra    <= '0;
      rb    <= '0;
    end else begin
      done <= 1'b0;
      if (state != RUN && start) begin
        ra    <= a;
        rb    <= sub ? ~b : b;
        carry <= sub | cin;
        k     <= '0;
        s     <= '0;
        state <= RUN;
        busy  <= 1'b1;
      end else if (state == RUN) begin
        s[off +: CHUNK] <= sl_s;
        carry           <= sl_c;
        if (last) begin
          cout  <= sl_c;
          ovf   <= sl_m ^ sl_c;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed and randomised checks on 32/8, 8/1 and 16/16 instances
module tb_seq_chunk_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic        sub = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  wire  [2:0]  dn, bz, co, ov;
  wire  [31:0] s32;
  wire  [7:0]  s8;
  wire  [15:0] s16;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(bz[0]), .done(dn[0]), .s(s32), .cout(co[0]), .ovf(ov[0]));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(bz[1]), .done(dn[1]), .s(s8), .cout(co[1]), .ovf(ov[1]));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .busy(bz[2]), .done(dn[2]), .s(s16), .cout(co[2]), .ovf(ov[2]));

  function automatic logic [31:0] res(input int sel);
    return (sel == 0) ? s32 : (sel == 1) ? {24'b0, s8} : {16'b0, s16};
  endfunction

  // Launch one operation on instance sel; lat counts edges from accept to done, bc counts busy cycles
  task automatic op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                    input logic sv, input logic cv, output int lat, output int bc);
    @(negedge clk);
    a = av; b = bv; sub = sv; cin = cv; start_v = 3'b001 << sel;
    lat = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start_v = '0;
      if (dn[sel]) break;
      bc += int'(bz[sel]);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bz[i], dn[i], co[i], ov[i], res(i)} !== 36'd0) begin
        n_bad++;
        $display("FAIL reset inst%0d: busy=%b done=%b cout=%b ovf=%b s=%h, required all 0",
                 i, bz[i], dn[i], co[i], ov[i], res(i));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, bc;
    op(0, 32'h0080_0800, 32'h0002_0000, 1'b0, 1'b0, lat, bc);
    n_cmp++;
    if ({s32, co[0], ov[0]} !== {32'h0082_0800, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL add: s=%h cout=%b ovf=%b, required 00820800 0 0", s32, co[0], ov[0]);
    end
    n_cmp++;
    if (lat !== 4 || bc !== 4) begin
      n_bad++;
      $display("FAIL add_latency: lat=%0d busy=%0d, required 4 4", lat, bc);
    end
    n_cmp++;
    if (bz[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_in_done: busy=%b, required 0", bz[0]);
    end
  endtask

  task automatic test_carry();
    int lat, bc;
    op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, bc);
    n_cmp++;
    if ({s32, co[0], ov[0]} !== {32'h0000_0000, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL carry_all: s=%h cout=%b ovf=%b, required 00000000 1 0", s32, co[0], ov[0]);
    end
    op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, bc);
    n_cmp++;
    if ({s32, co[0], ov[0]} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL carry_ovf: s=%h cout=%b ovf=%b, required 80000000 0 1", s32, co[0], ov[0]);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    op(0, 32'd5, 32'd7, 1'b1, 1'b1, lat, bc);
    n_cmp++;
    if ({s32, co[0], ov[0]} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_borrow: s=%h cout=%b ovf=%b, required fffffffe 0 0", s32, co[0], ov[0]);
    end
    op(0, 32'h8000_0000, 32'd1, 1'b1, 1'b0, lat, bc);
    n_cmp++;
    if ({s32, co[0], ov[0]} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_ovf: s=%h cout=%b ovf=%b, required 7fffffff 1 1", s32, co[0], ov[0]);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    @(negedge clk);
    a = 32'd1; b = 32'd2; sub = 1'b0; cin = 1'b0; start_v = 3'b001;
    @(negedge clk);
    a = 32'd100; b = 32'd200;
    @(negedge clk);
    start_v = '0;
    for (int i = 0; i < 20 && !dn[0]; i++) @(negedge clk);
    n_cmp++;
    if (dn[0] !== 1'b1 || s32 !== 32'd3) begin
      n_bad++;
      $display("FAIL start_in_run: done=%b s=%h, required 1 00000003", dn[0], s32);
    end
    a = 32'd10; b = 32'd20; start_v = 3'b001;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start_v = '0;
      gap++;
      if (dn[0]) break;
    end
    n_cmp++;
    if (gap !== 5 || s32 !== 32'd30) begin
      n_bad++;
      $display("FAIL back_to_back: gap=%0d s=%h, required 5 0000001e", gap, s32);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bz[0], dn[0], co[0], ov[0], s32} !== {4'b0000, 32'd30}) begin
      n_bad++;
      $display("FAIL idle_hold: busy=%b done=%b cout=%b ovf=%b s=%h, required 0 0 0 0 0000001e",
               bz[0], dn[0], co[0], ov[0], s32);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic seen;
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; cin = 1'b0; start_v = 3'b001;
    @(negedge clk);
    start_v = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bz[0], dn[0], co[0], ov[0], s32} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b cout=%b ovf=%b s=%h, required all 0",
               bz[0], dn[0], co[0], ov[0], s32);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= dn[0];
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_done: done seen=%b, required 0", seen);
    end
    op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat, bc);
    n_cmp++;
    if ({s32, co[0], ov[0], lat} !== {32'h2345_6789, 1'b0, 1'b0, 32'd4}) begin
      n_bad++;
      $display("FAIL after_reset: s=%h cout=%b ovf=%b lat=%0d, required 23456789 0 0 4",
               s32, co[0], ov[0], lat);
    end
  endtask

  task automatic test_sweep();
    int lat, bc;
    op(1, 32'hFF, 32'h01, 1'b0, 1'b1, lat, bc);
    n_cmp++;
    if ({s8, co[1], ov[1], lat, bc} !== {8'h01, 1'b1, 1'b0, 32'd8, 32'd8}) begin
      n_bad++;
      $display("FAIL sweep_8x1: s=%h cout=%b ovf=%b lat=%0d busy=%0d, required 01 1 0 8 8",
               s8, co[1], ov[1], lat, bc);
    end
    op(2, 32'h7FFF, 32'h0001, 1'b0, 1'b0, lat, bc);
    n_cmp++;
    if ({s16, co[2], ov[2], lat, bc} !== {16'h8000, 1'b0, 1'b1, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL sweep_16x16: s=%h cout=%b ovf=%b lat=%0d busy=%0d, required 8000 0 1 1 1",
               s16, co[2], ov[2], lat, bc);
    end
  endtask

  task automatic test_random();
    int lat, bc, w, elat;
    logic [32:0] m, av, bb, full;
    logic [31:0] ra, rb;
    logic sv, cv, ec, eo;
    for (int sel = 0; sel < 3; sel++) begin
      w    = (sel == 0) ? 32 : (sel == 1) ? 8 : 16;
      elat = (sel == 0) ? 4 : (sel == 1) ? 8 : 1;
      m    = (33'd1 << w) - 33'd1;
      for (int it = 0; it < 10; it++) begin
        ra = $urandom; rb = $urandom;
        sv = 1'($urandom_range(0, 1)); cv = 1'($urandom_range(0, 1));
        op(sel, ra, rb, sv, cv, lat, bc);
        av   = {1'b0, ra} & m;
        bb   = (sv ? ~{1'b0, rb} : {1'b0, rb}) & m;
        full = av + bb + {32'd0, sv | cv};
        ec   = full[w];
        eo   = (av[w-1] == bb[w-1]) && (full[w-1] != av[w-1]);
        n_cmp++;
        if ({res(sel), co[sel], ov[sel]} !== {full[31:0] & m[31:0], ec, eo}) begin
          n_bad++;
          $display("FAIL random inst%0d a=%h b=%h sub=%b cin=%b: s=%h cout=%b ovf=%b, required %h %b %b",
                   sel, ra, rb, sv, cv, res(sel), co[sel], ov[sel], full[31:0] & m[31:0], ec, eo);
        end
        n_cmp++;
        if (lat !== elat) begin
          n_bad++;
          $display("FAIL random_latency inst%0d: lat=%0d, required %0d", sel, lat, elat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
